norz_phase_sequencer: RTL

- Drives the instruction-decoder tree: fetches the opcode, holds it on ITABLE/notITABLE and steps the phase counter XPT/notXPT.
- Consumes the end-of-instruction pulses the decoders emit: PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE and Pa_Ophd.
- Sits between the memory-interface handshake and the top-level DECODER_I enable.

---
 rtl/norz_phase_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/norz_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : norz_phase_sequencer
//  Purpose  : Opcode fetch and phase sequencer for the instruction-decoder
//             tree. It fetches an opcode over the memory handshake, holds it
//             on ITABLE/notITABLE, steps the phase counter XPT/notXPT and
//             consumes the decoder end-of-instruction pulses.
//  Ports    : CLK, RESET (sync, active-high)
//             mem_req / mem_ack / mem_rdata : opcode fetch handshake
//             stall                         : freezes XPT advance
//             PR_Reset_XPT, P2_Set_CM1,
//             P2_Reset_ITABLE, Pa_Ophd      : decoder control pulses
//             enable, XPT, notXPT, ITABLE,
//             notITABLE, CM1                : decoder-tree drive
//             fault                         : sticky phase-overrun flag
//             instr_cnt                     : retired-instruction count
//  Options  : NORZ_SEQ_PREFETCH_EN - one-entry opcode prefetch buffer that
//             lets P2_Set_CM1 skip the FETCH handshake when it holds data.
//  Revision : 1.0 - initial release
// ============================================================================
module norz_phase_sequencer #(
    parameter int XPT_MAX = 15,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             mem_req,
    input  logic             mem_ack,
    input  logic [7:0]       mem_rdata,
    input  logic             stall,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             P2_Reset_ITABLE,
    input  logic             Pa_Ophd,
    output logic             enable,
    output logic [3:0]       XPT,
    output logic [3:0]       notXPT,
    output logic [7:0]       ITABLE,
    output logic [7:0]       notITABLE,
    output logic             CM1,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] XPT_LAST = 4'(XPT_MAX);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;

`ifdef NORZ_SEQ_PREFETCH_EN
    logic [7:0] pf_buf;
    logic       pf_valid;
    logic       pf_pending;
`endif

    // Complements are written alongside their true values on every update so
    // both rails change on the same edge and never pass through logic.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_FETCH;
            mem_req   <= 1'b0;
            enable    <= 1'b0;
            XPT       <= 4'h0;
            notXPT    <= 4'hF;
            ITABLE    <= 8'h00;
            notITABLE <= 8'hFF;
            CM1       <= 1'b1;
            fault     <= 1'b0;
            instr_cnt <= '0;
`ifdef NORZ_SEQ_PREFETCH_EN
            pf_buf     <= 8'h00;
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    // An ack only completes a fetch that was actually requested.
                    if (mem_req && mem_ack) begin
                        ITABLE    <= mem_rdata;
                        notITABLE <= ~mem_rdata;
                        XPT       <= 4'h0;
                        notXPT    <= 4'hF;
                        CM1       <= 1'b0;
                        mem_req   <= 1'b0;
                        enable    <= 1'b1;
                        state     <= ST_EXEC;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end

                ST_EXEC: begin
                    CM1 <= 1'b0;

                    if (Pa_Ophd)
                        instr_cnt <= instr_cnt + 1'b1;

                    if (P2_Reset_ITABLE) begin
                        ITABLE    <= 8'h00;
                        notITABLE <= 8'hFF;
                    end

`ifdef NORZ_SEQ_PREFETCH_EN
                    // Prefetch traffic first; the phase logic below may
                    // override mem_req when leaving EXEC.
                    if (pf_pending && mem_ack) begin
                        pf_buf     <= mem_rdata;
                        pf_valid   <= 1'b1;
                        pf_pending <= 1'b0;
                        mem_req    <= 1'b0;
                    end else if (!pf_pending && !pf_valid && !stall && !P2_Set_CM1) begin
                        pf_pending <= 1'b1;
                        mem_req    <= 1'b1;
                    end
                    if (P2_Reset_ITABLE)
                        pf_valid <= 1'b0;
`endif

                    if (P2_Set_CM1) begin
                        XPT    <= 4'h0;
                        notXPT <= 4'hF;
`ifdef NORZ_SEQ_PREFETCH_EN
                        if (pf_valid) begin
                            // Buffered opcode: reload and stay in EXEC, with a
                            // single-cycle CM1 marking the new M1 cycle.
                            ITABLE    <= pf_buf;
                            notITABLE <= ~pf_buf;
                            CM1       <= 1'b1;
                            pf_valid  <= 1'b0;
                        end else begin
                            state      <= ST_FETCH;
                            CM1        <= 1'b1;
                            mem_req    <= 1'b1;
                            enable     <= 1'b0;
                            pf_valid   <= 1'b0;
                            pf_pending <= 1'b0;
                        end
`else
                        state   <= ST_FETCH;
                        CM1     <= 1'b1;
                        mem_req <= 1'b1;
                        enable  <= 1'b0;
`endif
                    end else if (PR_Reset_XPT) begin
                        XPT    <= 4'h0;
                        notXPT <= 4'hF;
                    end else if (!stall) begin
                        if (XPT == XPT_LAST) begin
                            // Phase overrun: freeze at the last phase, never wrap.
                            fault   <= 1'b1;
                            enable  <= 1'b0;
                            mem_req <= 1'b0;
                            state   <= ST_HALT;
`ifdef NORZ_SEQ_PREFETCH_EN
                            pf_pending <= 1'b0;
`endif
                        end else begin
                            XPT    <= XPT + 4'd1;
                            notXPT <= ~(XPT + 4'd1);
                        end
                    end
                end

                default: begin
                    // ST_HALT: everything frozen until RESET.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
